// File: rtl/hash_arbiter_if.sv
// Shared types and the bus interface of hash_arbiter.
// hash_arbiter_pkg holds the flow 5-tuple. hash_arbiter_if groups the
// requester, hash-unit and result signals. The slave modport is the arbiter
// side and the master modport is the surrounding logic.

package hash_arbiter_pkg;
   typedef struct packed {
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [7:0]  proto;
   } tuple_t;
endpackage

interface hash_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2
);
   import hash_arbiter_pkg::*;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   tuple_t [NUM_REQ-1:0]     req_tuple;
   logic [NUM_REQ-1:0][31:0] req_initval;

   logic                     hash_stall;
   tuple_t                   hash_tuple;
   logic [31:0]              hash_initval;
   logic                     hash_in_valid;
   logic                     hash_valid;
   logic [31:0]              hash_out;

   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_hash;
   logic [TAG_W-1:0]         out_tag;

   logic                     err_orphan;
   logic [NUM_REQ-1:0][31:0] stat_grant_cnt;

   modport slave (
      input  req_valid, req_tuple, req_initval, hash_valid, hash_out, out_ready,
      output req_ready, hash_stall, hash_tuple, hash_initval, hash_in_valid,
             out_valid, out_hash, out_tag, err_orphan, stat_grant_cnt
   );

   modport master (
      output req_valid, req_tuple, req_initval, hash_valid, hash_out, out_ready,
      input  req_ready, hash_stall, hash_tuple, hash_initval, hash_in_valid,
             out_valid, out_hash, out_tag, err_orphan, stat_grant_cnt
   );
endinterface

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin arbiter in front of a shared, pipelined hash unit.
// Each issue pushes its requester index into an in-order tag FIFO. The hash
// unit returns results in issue order, so the FIFO head is the tag of the
// current result.
// Optional feature: define HASH_ARB_STATS_EN to build saturating per-requester
// grant counters. Without the macro, stat_grant_cnt is tied to zero.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_FLUSH | drain the unreset hash pipeline for HASH_LAT cycles, no issue
// ST_RUN   | arbitrate, issue, tag and present results

module hash_arbiter
   import hash_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int TAG_W    = 2,
   parameter int HASH_LAT = 8
) (
   input  logic          clk,
   input  logic          rst,
   hash_arbiter_if.slave bus
);
   localparam int FIFO_DEPTH = HASH_LAT + 1;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int FL_W       = $clog2(HASH_LAT + 1);

   typedef enum logic [0:0] {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [TAG_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_orphan_q, err_orphan_d;
   logic [TAG_W-1:0] tag_mem_q [FIFO_DEPTH];
   logic [TAG_W-1:0] tag_mem_d [FIFO_DEPTH];

   logic               run;
   logic               stall;
   logic               found;
   logic [TAG_W:0]     cand;
   logic [TAG_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic               res_valid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Flush sequencing and round-robin grant selection starting at ptr_q.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      ptr_d       = ptr_q;
      stall       = 1'b0;
      found       = 1'b0;
      cand        = '0;
      grant_idx   = '0;
      grant       = '0;
      run         = (state_q == ST_RUN) && !rst;

      case (state_q)
         ST_FLUSH: begin
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == FL_W'(1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
         end
         default: state_d = ST_FLUSH;
      endcase

      if (run) begin
         stall = bus.hash_valid & ~bus.out_ready;
         if (!stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               cand = {1'b0, ptr_q} + (TAG_W+1)'(i);
               if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                  cand = cand - (TAG_W+1)'(NUM_REQ);
               end
               if (!found && bus.req_valid[cand[TAG_W-1:0]]) begin
                  found     = 1'b1;
                  grant_idx = cand[TAG_W-1:0];
               end
            end
         end
         if (found) begin
            grant[grant_idx] = 1'b1;
            ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Issue mux, tag FIFO bookkeeping and result presentation.
   always_comb begin
      tag_mem_d    = tag_mem_q;
      fifo_empty   = (count_q == '0);
      push         = run & found;
      res_valid    = run & bus.hash_valid;
      pop          = res_valid & bus.out_ready & ~fifo_empty;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_orphan_d = err_orphan_q | (res_valid & fifo_empty);

      if (push) begin
         tag_mem_d[wr_ptr_q] = grant_idx;
         wr_ptr_d            = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      bus.req_ready     = grant;
      bus.hash_stall    = stall;
      bus.hash_in_valid = push;
      bus.hash_tuple    = rst ? '0 : bus.req_tuple[grant_idx];
      bus.hash_initval  = rst ? '0 : bus.req_initval[grant_idx];
      bus.out_valid     = res_valid;
      bus.out_hash      = res_valid ? bus.hash_out : '0;
      bus.out_tag       = (res_valid && !fifo_empty) ? tag_mem_q[rd_ptr_q] : '0;
      bus.err_orphan    = err_orphan_q & ~rst;
   end

   // State, arbitration pointer and tag FIFO control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FLUSH;
         flush_cnt_q  <= FL_W'(HASH_LAT);
         ptr_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         ptr_q        <= ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   // Tag storage. Entries are only read between their push and their pop.
   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
   end

   // In-flight results never exceed HASH_LAT, so a push into a full FIFO
   // without a pop means the hash unit misbehaved.
   assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

`ifdef HASH_ARB_STATS_EN
   logic [NUM_REQ-1:0][31:0] stat_q, stat_d;

   // Saturating grant counters.
   always_comb begin
      stat_d = stat_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
            stat_d[i] = stat_q[i] + 32'd1;
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign bus.stat_grant_cnt = rst ? '0 : stat_q;
`else
   assign bus.stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter.
// A behavioural stand-in for the hash unit is an 8-stage pipe. It holds while
// stalled and uses a simple mixing function. An override injects stray
// hashed_valid pulses.
module tb_hash_arbiter;
   import hash_arbiter_pkg::*;

   localparam int NUM_REQ  = 4;
   localparam int TAG_W    = 2;
   localparam int HASH_LAT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_hv = 1'b0;
   int   checks = 0;
   int   failures = 0;

   tuple_t      tup [NUM_REQ];
   logic [31:0] iv  [NUM_REQ];

   hash_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

   hash_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .HASH_LAT(HASH_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fh(input tuple_t t, input logic [31:0] s);
      return t.sip ^ {t.dip[15:0], t.dip[31:16]} ^ {t.sport, t.dport} ^
             {24'h0, t.proto} ^ s ^ 32'h9E37_79B9;
   endfunction

   // Hash unit stand-in.
   logic        pv [HASH_LAT];
   logic [31:0] ph [HASH_LAT];
   initial for (int i = 0; i < HASH_LAT; i++) begin pv[i] = 1'b0; ph[i] = '0; end
   always @(posedge clk) begin
      if (!bus.hash_stall) begin
         pv[0] <= bus.hash_in_valid;
         ph[0] <= fh(bus.hash_tuple, bus.hash_initval);
         for (int i = 1; i < HASH_LAT; i++) begin
            pv[i] <= pv[i-1];
            ph[i] <= ph[i-1];
         end
      end
   end
   assign bus.hash_valid = pv[HASH_LAT-1] | force_hv;
   assign bus.hash_out   = force_hv ? 32'hDEAD_0000 : ph[HASH_LAT-1];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_tuple[i]   = tup[i];
         bus.req_initval[i] = iv[i];
      end
   end

   // Accepted results, in order.
   int unsigned got_tag [$];
   logic [31:0] got_hash [$];
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         got_tag.push_back(32'(bus.out_tag));
         got_hash.push_back(bus.out_hash);
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_results(input string name, input int unsigned exp_tags [$]);
      chk({name, "_count"}, 128'(got_tag.size()), 128'(exp_tags.size()));
      for (int i = 0; i < exp_tags.size(); i++) begin
         if (i < got_tag.size()) begin
            chk({name, "_tag"}, 128'(got_tag[i]), 128'(exp_tags[i]));
            chk({name, "_hash"}, 128'(got_hash[i]), 128'(fh(tup[exp_tags[i]], iv[exp_tags[i]])));
         end
      end
      got_tag.delete();
      got_hash.delete();
   endtask

   typedef struct {
      logic [3:0] rv;
      logic [3:0] rdy;
      int         idx;
   } vec_t;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vec [14];
      int unsigned exp_q [$];
      int ov_cnt;
      logic [31:0] exp_stat [NUM_REQ];

      // Starting from ptr=3.
      vec[0]  = '{4'b1111, 4'b1000, 3};
      vec[1]  = '{4'b1111, 4'b0001, 0};
      vec[2]  = '{4'b1111, 4'b0010, 1};
      vec[3]  = '{4'b1111, 4'b0100, 2};
      vec[4]  = '{4'b1111, 4'b1000, 3};
      vec[5]  = '{4'b0000, 4'b0000, 0};
      vec[6]  = '{4'b1010, 4'b0010, 1};
      vec[7]  = '{4'b1010, 4'b1000, 3};
      vec[8]  = '{4'b0001, 4'b0001, 0};
      vec[9]  = '{4'b0001, 4'b0001, 0};
      vec[10] = '{4'b0110, 4'b0010, 1};
      vec[11] = '{4'b0110, 4'b0100, 2};
      vec[12] = '{4'b0110, 4'b0010, 1};
      vec[13] = '{4'b1001, 4'b1000, 3};

      for (int i = 0; i < NUM_REQ; i++) begin
         tup[i] = '{sip: 32'hC0A8_0000 + 32'(i), dip: 32'h0A0A_0000 + 32'(i * 17),
                    sport: 16'(1000 + i), dport: 16'd80, proto: 8'd6};
         iv[i]  = 32'h0000_1000 * 32'(i);
      end
      tup[2].sip = 32'h0A00_0001;
      iv[2]      = 32'h0;

      // Reset: outputs low even with requests and stray hash_valid.
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      force_hv      = 1'b1;
      repeat (3) next();
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 4'b0000);
      chk("rst_in_valid", bus.hash_in_valid, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_stall", bus.hash_stall, 1'b0);
      chk("rst_err", bus.err_orphan, 1'b0);
      chk("rst_stat", bus.stat_grant_cnt, 128'h0);

      // Flush: 8 cycles with nothing issued and stray results discarded.
      next();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < HASH_LAT; c++) begin
         @(negedge clk);
         chk("flush_req_ready", bus.req_ready, 4'b0000);
         chk("flush_out_valid", bus.out_valid, 1'b0);
         chk("flush_stall", bus.hash_stall, 1'b0);
         chk("flush_in_valid", bus.hash_in_valid, 1'b0);
         next();
      end
      force_hv = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_first_grant", bus.req_ready, 4'b0001);
      chk("flush_first_tuple", bus.hash_tuple, tup[0]);
      next();
      bus.req_valid = 4'b0000;
      repeat (10) next();
      exp_q = '{0};
      chk_results("flush_result", exp_q);

      // Single request from requester 2, with ptr at 1. Exact latency is HASH_LAT.
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("single_grant", bus.req_ready, 4'b0100);
      chk("single_initval", bus.hash_initval, 32'h0);
      next();
      bus.req_valid = 4'b0000;
      for (int k = 1; k <= HASH_LAT; k++) begin
         @(negedge clk);
         chk("single_latency", bus.out_valid, (k == HASH_LAT));
         if (k == HASH_LAT) begin
            chk("single_tag", bus.out_tag, 2'd2);
            chk("single_hash", bus.out_hash, fh(tup[2], 32'h0));
         end
         next();
      end
      got_tag.delete();
      got_hash.delete();

      // Table-driven arbitration sequence.
      exp_q = '{};
      for (int r = 0; r < 14; r++) begin
         bus.req_valid = vec[r].rv;
         @(negedge clk);
         chk("arb_ready", bus.req_ready, vec[r].rdy);
         chk("arb_issue", bus.hash_in_valid, (vec[r].rdy != 4'b0000));
         if (vec[r].rdy != 4'b0000) begin
            chk("arb_tuple", bus.hash_tuple, tup[vec[r].idx]);
            exp_q.push_back(vec[r].idx);
         end
         next();
      end
      bus.req_valid = 4'b0000;
      repeat (12) next();
      chk_results("arb_results", exp_q);

      // Backpressure, with ptr at 0. Grants 0,1,2 are issued, then a 5-cycle
      // stall on the first result.
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_grant", bus.req_ready, 4'(1 << k));
         next();
      end
      bus.req_valid = 4'b0000;
      repeat (5) next();
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_stall", bus.hash_stall, 1'b1);
         chk("bp_req_ready", bus.req_ready, 4'b0000);
         chk("bp_out_valid", bus.out_valid, 1'b1);
         chk("bp_out_tag", bus.out_tag, 2'd0);
         chk("bp_out_hash", bus.out_hash, fh(tup[0], iv[0]));
         next();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", bus.req_ready, 4'b1000);
      next();
      bus.req_valid = 4'b0000;
      repeat (12) next();
      exp_q = '{0, 1, 2, 3};
      chk_results("bp_results", exp_q);

      // Reset mid-flight: five issues, then one reset cycle.
      bus.req_valid = 4'b1111;
      repeat (5) next();
      bus.req_valid = 4'b0000;
      rst = 1'b1;
      ov_cnt = 0;
      @(negedge clk);
      ov_cnt += int'(bus.out_valid);
      next();
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         ov_cnt += int'(bus.out_valid);
         next();
      end
      chk("midrst_no_results", 128'(ov_cnt), 128'd0);
      chk("midrst_err", bus.err_orphan, 1'b0);
      chk("midrst_stat", bus.stat_grant_cnt, 128'h0);
      exp_q = '{};
      chk_results("midrst_results", exp_q);

      // Stats: 10 grants to requester 1 and 3 grants to requester 3.
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stat_grant1", bus.req_ready, 4'b0010);
         next();
      end
      bus.req_valid = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stat_grant3", bus.req_ready, 4'b1000);
         next();
      end
      bus.req_valid = 4'b0000;
`ifdef HASH_ARB_STATS_EN
      exp_stat = '{32'd0, 32'd10, 32'd0, 32'd3};
`else
      exp_stat = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         chk("stat_cnt", bus.stat_grant_cnt[i], exp_stat[i]);
      end
      next();
      repeat (12) next();
      got_tag.delete();
      got_hash.delete();

      // Orphan: a result with the FIFO empty is shown with tag 0 and sets a
      // sticky flag.
      force_hv = 1'b1;
      @(negedge clk);
      chk("orphan_out_valid", bus.out_valid, 1'b1);
      chk("orphan_out_tag", bus.out_tag, 2'd0);
      chk("orphan_out_hash", bus.out_hash, 32'hDEAD_0000);
      chk("orphan_err_pre", bus.err_orphan, 1'b0);
      next();
      force_hv = 1'b0;
      @(negedge clk);
      chk("orphan_err_set", bus.err_orphan, 1'b1);
      repeat (3) next();
      @(negedge clk);
      chk("orphan_err_sticky", bus.err_orphan, 1'b1);
      next();
      rst = 1'b1;
      @(negedge clk);
      chk("orphan_err_rst", bus.err_orphan, 1'b0);
      next();
      rst = 1'b0;
      @(negedge clk);
      chk("orphan_err_cleared", bus.err_orphan, 1'b0);
      next();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
